// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: handshake and data bundle for the bit-serial subtractor.
//   master : drives start, a, b (and sub when SERIAL_SUB_ADD_MODE_EN is defined)
//   slave  : drives busy, done, diff, borrow_out, overflow
// Optional macro SERIAL_SUB_ADD_MODE_EN adds the sub select line.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

`ifdef SERIAL_SUB_ADD_MODE_EN
  modport master (output start, a, b, sub,
                  input  busy, done, diff, borrow_out, overflow);
  modport slave  (input  start, a, b, sub,
                  output busy, done, diff, borrow_out, overflow);
`else
  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out, overflow);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out, overflow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement DIFF = A - B, LSB first,
// built as A + ~B + 1 through one full-adder cell with a registered carry.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/a/b in; busy/done/diff/borrow_out/overflow out)
// Optional macro SERIAL_SUB_ADD_MODE_EN: adds bus.sub; sub=0 computes A + B and
// borrow_out then reports the carry-out.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accepted start
// LOAD  | preset carry and bit counter
// SHIFT | one result bit per cycle, LSB first
// DONE  | one-cycle done pulse, result registers already updated
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             sub_q, sub_d;

  logic sum_bit;
  logic carry_nx;

  assign sum_bit  = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign carry_nx = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    sub_d    = sub_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef SERIAL_SUB_ADD_MODE_EN
          sub_d = bus.sub;
          sb_d  = bus.sub ? ~bus.b : bus.b;
`else
          sub_d = 1'b1;
          sb_d  = ~bus.b;
`endif
          sa_d    = bus.a;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Carry-in of 1 completes the two's complement of b.
        carry_d = sub_q;
        cnt_d   = '0;
        res_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = carry_nx;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, carry_nx the carry out of it.
          diff_d   = {sum_bit, res_q[WIDTH-1:1]};
          borrow_d = sub_q ? ~carry_nx : carry_nx;
          ovf_d    = carry_q ^ carry_nx;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      sub_q    <= sub_d;
    end
  end

  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing DIFF = A − B, one bit per clock, LSB first.
- Reuses a single full-adder cell with a registered carry: A + ~B + 1.
- It is the inverse-operation companion to the 4-bit ripple adder lab. It gives the ALU datapath an area-cheap subtract unit with a start/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while in LOAD or SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result; held until the next accepted start.
- borrow_out  output  1  1 when a < b (unsigned), i.e. ~final carry.
- overflow  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - FSM goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0, overflow=0.
  - Internal shift registers, bit counter and carry are cleared.
  - Reset during SHIFT aborts the operation with no done pulse. The first start after release is accepted normally.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 → LOAD; latch a into sa and ~b into sb.
  - start=0 → stay in IDLE.
- LOAD: set carry=1, counter=0, busy=1 → SHIFT.
- SHIFT, each cycle:
  - s = sa[0]^sb[0]^carry.
  - carry' = (sa[0]&sb[0]) | (carry&(sa[0]^sb[0])).
  - Result register shifts right with s entering at the MSB.
  - sa and sb shift right; counter increments.
  - When counter == WIDTH−1: record cin_msb = carry (carry before the MSB add) and move to DONE after this bit.
- DONE, for one cycle:
  - diff = result register; borrow_out = ~carry_final; overflow = cin_msb ^ carry_final.
  - done=1, busy=0 → IDLE.
- Latency: start seen at edge N → done=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles from start to done.
- start while busy or in DONE is ignored (not queued).
- start in the same cycle done is high is ignored; it is accepted only in IDLE.
- diff, borrow_out and overflow change only on the transition into DONE. They are stable between done pulses.
- Width rules:
  - Result wraps modulo 2^WIDTH.
  - Counter width is clog2(WIDTH).
  - No outputs are combinational from inputs.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- When defined:
  - Adds port "sub  input  1". It is captured with the operands on an accepted start.
  - sub=1: subtract as above.
  - sub=0: sb latches b (not ~b), initial carry=0, and diff = a+b.
  - borrow_out then reports carry-out (1 when a+b ≥ 2^WIDTH); overflow keeps the signed rule.
- When undefined: no sub port; always subtracts.

Test Plan (WIDTH=4):
- Basic subtract: a=7, b=3, start pulse → done after 6 cycles; diff=4'b0100, borrow_out=0, overflow=0.
- Borrow: a=3, b=7 → diff=4'b1100, borrow_out=1, overflow=0.
- Signed overflow: a=4'b1000, b=4'b0001 → diff=4'b0111, borrow_out=0, overflow=1.
- Zero and handshake:
  - a=0, b=0 → diff=0, borrow_out=0, overflow=0.
  - A second start pulsed while busy=1 → ignored; exactly one done pulse.
- Reset mid-operation: start a=9, b=2, assert rst_n=0 in the 3rd SHIFT cycle → all outputs 0 immediately, no done. Release, then start a=9, b=2 → diff=7, borrow_out=0.
- With SERIAL_SUB_ADD_MODE_EN: sub=0, a=9, b=8 → diff=4'b0001, borrow_out=1, overflow=1. Then sub=1, a=9, b=8 → diff=1, borrow_out=0, overflow=0.
